// File: rtl/alu_issue.sv
// Single-issue front end for an external combinational ALU: register file,
// one EX stage with result forwarding, writeback, flag capture and retire count.
module alu_issue #(
  parameter int N    = 8,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  output logic [3:0]    alu_op,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_y,
  input  logic          alu_flg,
  output logic          flag,
  output logic [15:0]   retired,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0]  regs_q [NREG];
  logic [N-1:0]  regs_d [NREG];
  logic          ex_valid_q, ex_valid_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic          flag_q, flag_d;
  logic [15:0]   retired_q, retired_d;
  logic          accept;
  logic [N-1:0]  opa, opb;

  assign in_ready = !ld_en;
  assign accept   = in_valid && !ld_en;

  // Operand read: the in-flight EX result bypasses the register file.
  assign opa = (ex_valid_q && (ex_rd_q == in_rs1)) ? alu_y : regs_q[in_rs1];
  assign opb = (ex_valid_q && (ex_rd_q == in_rs2)) ? alu_y : regs_q[in_rs2];

  always_comb begin
    regs_d = regs_q;
    if (ex_valid_q) regs_d[ex_rd_q] = alu_y;
    // External load is applied last so it wins a same-register collision.
    if (ld_en) regs_d[ld_addr] = ld_data;

    ex_valid_d = accept;
    ex_rd_d    = accept ? in_rd  : ex_rd_q;
    alu_op_d   = accept ? in_op  : alu_op_q;
    alu_a_d    = accept ? opa    : alu_a_q;
    alu_b_d    = accept ? opb    : alu_b_q;

    flag_d    = ex_valid_q ? alu_flg : flag_q;
    retired_d = ex_valid_q ? (retired_q + 16'd1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      flag_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      flag_q     <= flag_d;
      retired_q  <= retired_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign flag    = flag_q;
  assign retired = retired_q;
  assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the EX port, architectural register
// model, and a queue of expected writebacks checked after the pipeline drains.
module tb_alu_issue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_flg;
  logic       flag;
  logic [15:0] retired;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
    logic       flg;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [7:0]  mreg [8];
  logic [15:0] ret_exp;
  int          n_chk;
  int          n_fail;

  alu_issue #(.N(8), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_flg(alu_flg),
    .flag(flag), .retired(retired),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Returns {flag, result}; flag is the result sign bit.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0]        y;
    logic signed [7:0] sa;
    sa = a;
    case (op)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << b[2:0];
      4'd6: y = a >> b[2:0];
      4'd7: y = sa >>> b[2:0];
      default: y = a ^ b ^ {4'h0, op};
    endcase
    return {y[7], y};
  endfunction

  assign {alu_flg, alu_y} = alu_f(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ld_en    = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    in_valid = 1'b0;
    ld_en    = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    mreg[a]  = d;
    tick();
    ld_en    = 1'b0;
  endtask

  // Leaves in_valid high so consecutive calls issue back to back.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit push);
    logic [8:0] r;
    exp_t       x;
    ld_en    = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    r = alu_f(op, mreg[rs1], mreg[rs2]);
    x.rd  = rd;
    x.val = r[7:0];
    x.flg = r[8];
    if (push) sbq.push_back(x);
    mreg[rd] = r[7:0];
    ret_exp  = ret_exp + 16'd1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    ret_exp = '0;
    #2;
    n_chk++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL reset_alu_op: got %h expected 0", alu_op); end
    n_chk++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 00", alu_a); end
    n_chk++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 00", alu_b); end
    n_chk++; if (flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b expected 0", flag); end
    n_chk++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL reset_retired: got %h expected 0000", retired); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    ld_en = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_ld: got %b expected 0", in_ready); end
    ld_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, rd_data); end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    n_chk++; if (alu_op !== 4'd0) begin n_fail++; $display("FAIL basic_alu_op: got %h expected 0", alu_op); end
    n_chk++; if (alu_a !== 8'h05) begin n_fail++; $display("FAIL basic_alu_a: got %h expected 05", alu_a); end
    n_chk++; if (alu_b !== 8'h03) begin n_fail++; $display("FAIL basic_alu_b: got %h expected 03", alu_b); end
    idle();
    n_chk++; if (retired !== ret_exp) begin n_fail++; $display("FAIL basic_retired: got %h expected %h", retired, ret_exp); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.rd;
      #1;
      n_chk++; if (rd_data !== e.val) begin n_fail++; $display("FAIL basic_r%0d: got %h expected %h", e.rd, rd_data, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    do_load(3'd3, 8'h00);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    issue(4'd1, 3'd4, 3'd3, 3'd1, 1'b1);
    n_chk++; if (alu_op !== 4'd1) begin n_fail++; $display("FAIL b2b_alu_op: got %h expected 1", alu_op); end
    n_chk++; if (alu_a !== 8'h08) begin n_fail++; $display("FAIL b2b_fwd_a: got %h expected 08", alu_a); end
    n_chk++; if (alu_b !== 8'h05) begin n_fail++; $display("FAIL b2b_alu_b: got %h expected 05", alu_b); end
    idle();
    n_chk++; if (retired !== ret_exp) begin n_fail++; $display("FAIL b2b_retired: got %h expected %h", retired, ret_exp); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.rd;
      #1;
      n_chk++; if (rd_data !== e.val) begin n_fail++; $display("FAIL b2b_r%0d: got %h expected %h", e.rd, rd_data, e.val); end
    end
  endtask

  task automatic test_ld_stall();
    in_valid = 1'b1; in_op = 4'd0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 8'h11;
    mreg[7] = 8'h11;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    tick();
    idle();
    n_chk++; if (retired !== ret_exp) begin n_fail++; $display("FAIL stall_retired: got %h expected %h", retired, ret_exp); end
    rd_addr = 3'd6;
    #1;
    n_chk++; if (rd_data !== mreg[6]) begin n_fail++; $display("FAIL stall_r6: got %h expected %h", rd_data, mreg[6]); end
    rd_addr = 3'd7;
    #1;
    n_chk++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL stall_r7: got %h expected 11", rd_data); end
    // Writeback and load hit r3 on the same edge.
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1);
    do_load(3'd3, 8'hAA);
    void'(sbq.pop_front());
    rd_addr = 3'd3;
    #1;
    n_chk++; if (rd_data !== 8'hAA) begin n_fail++; $display("FAIL collide_r3: got %h expected aa", rd_data); end
    n_chk++; if (retired !== ret_exp) begin n_fail++; $display("FAIL collide_retired: got %h expected %h", retired, ret_exp); end
    issue(4'd4, 3'd5, 3'd1, 3'd2, 1'b1);
    do_load(3'd6, 8'h66);
    rd_addr = 3'd6;
    #1;
    n_chk++; if (rd_data !== 8'h66) begin n_fail++; $display("FAIL split_r6: got %h expected 66", rd_data); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.rd;
      #1;
      n_chk++; if (rd_data !== e.val) begin n_fail++; $display("FAIL split_r%0d: got %h expected %h", e.rd, rd_data, e.val); end
    end
  endtask

  task automatic test_shift();
    do_load(3'd1, 8'h81);
    do_load(3'd2, 8'h01);
    issue(4'd7, 3'd5, 3'd1, 3'd2, 1'b1);
    n_chk++; if (alu_op !== 4'd7) begin n_fail++; $display("FAIL shift_op_sra: got %h expected 7", alu_op); end
    issue(4'd5, 3'd6, 3'd1, 3'd2, 1'b1);
    n_chk++; if (alu_op !== 4'd5) begin n_fail++; $display("FAIL shift_op_sll: got %h expected 5", alu_op); end
    n_chk++; if (flag !== sbq[0].flg) begin n_fail++; $display("FAIL shift_flag_sra: got %b expected %b", flag, sbq[0].flg); end
    idle();
    n_chk++; if (flag !== sbq[1].flg) begin n_fail++; $display("FAIL shift_flag_sll: got %b expected %b", flag, sbq[1].flg); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.rd;
      #1;
      n_chk++; if (rd_data !== e.val) begin n_fail++; $display("FAIL shift_r%0d: got %h expected %h", e.rd, rd_data, e.val); end
    end
  endtask

  task automatic test_rs_equal();
    logic [7:0] fwd;
    issue(4'd4, 3'd4, 3'd1, 3'd2, 1'b1);
    fwd = mreg[4];
    issue(4'd12, 3'd7, 3'd4, 3'd4, 1'b1);
    n_chk++; if (alu_op !== 4'd12) begin n_fail++; $display("FAIL req_op12: got %h expected c", alu_op); end
    n_chk++; if (alu_a !== fwd) begin n_fail++; $display("FAIL req_a: got %h expected %h", alu_a, fwd); end
    n_chk++; if (alu_b !== fwd) begin n_fail++; $display("FAIL req_b: got %h expected %h", alu_b, fwd); end
    idle();
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.rd;
      #1;
      n_chk++; if (rd_data !== e.val) begin n_fail++; $display("FAIL req_r%0d: got %h expected %h", e.rd, rd_data, e.val); end
    end
  endtask

  task automatic test_wrap();
    int k;
    k = 65535 - int'(ret_exp);
    for (int i = 0; i < k; i++) issue(4'd2, 3'd0, 3'd0, 3'd0, 1'b0);
    idle();
    n_chk++; if (retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h expected ffff", retired); end
    issue(4'd2, 3'd0, 3'd0, 3'd0, 1'b0);
    idle();
    n_chk++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", retired); end
  endtask

  task automatic test_reset_mid();
    issue(4'd1, 3'd6, 3'd2, 3'd1, 1'b0);
    issue(4'd0, 3'd5, 3'd1, 3'd2, 1'b0);
    in_valid = 1'b0;
    n_chk++; if (flag !== 1'b1) begin n_fail++; $display("FAIL mid_flag_pre: got %b expected 1", flag); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL mid_alu_a: got %h expected 00", alu_a); end
    n_chk++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL mid_alu_b: got %h expected 00", alu_b); end
    n_chk++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL mid_alu_op: got %h expected 0", alu_op); end
    n_chk++; if (flag !== 1'b0) begin n_fail++; $display("FAIL mid_flag: got %b expected 0", flag); end
    n_chk++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL mid_retired: got %h expected 0000", retired); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    sbq.delete();
    ret_exp = '0;
    rd_addr = 3'd5;
    #1;
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_r5: got %h expected 00", rd_data); end
    n_chk++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL mid_retired_post: got %h expected 0000", retired); end
    issue(4'd3, 3'd2, 3'd0, 3'd0, 1'b0);
    n_chk++; if (alu_op !== 4'd3) begin n_fail++; $display("FAIL first_edge_op: got %h expected 3", alu_op); end
    idle();
    n_chk++; if (retired !== ret_exp) begin n_fail++; $display("FAIL first_edge_retired: got %h expected %h", retired, ret_exp); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ld_stall();
    test_shift();
    test_rs_equal();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
